// File: rtl/dmem_bus_ctrl_pkg.sv
// dmem_bus_ctrl_pkg: size and state codes shared by the data-memory access unit and the core decoder
package dmem_bus_ctrl_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
endpackage

// File: rtl/dmem_bus_ctrl_if.sv
// dmem_bus_ctrl_if: word-wide req/ack data-memory bus
interface dmem_bus_ctrl_if #(parameter int ADDR_W = 32);
  logic b_req;
  logic b_we;
  logic [3:0] b_be;
  logic [ADDR_W-1:0] b_addr;
  logic [31:0] b_wdata;
  logic [31:0] b_rdata;
  logic b_ack;
  modport master(output b_req, b_we, b_be, b_addr, b_wdata, input b_rdata, b_ack);
  modport slave(input b_req, b_we, b_be, b_addr, b_wdata, output b_rdata, b_ack);
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte enables, store lane replication, load right-alignment; mis only under DMEM_MISALIGN_TRAP_EN
module dmem_lane_align
  import dmem_bus_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  a,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] aligned_rdata,
  output logic        mis
);
  logic [1:0] off;
  logic [31:0] sh;
  always_comb begin
    off = size == SZ_BYTE ? a : size == SZ_HALF ? {a[1], 1'b0} : 2'b00;
    be = size == SZ_BYTE ? 4'b0001 << off : size == SZ_HALF ? 4'b0011 << off : 4'b1111;
    lane_wdata = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    sh = rdata >> {off, 3'b000};
    aligned_rdata = size == SZ_BYTE ? {24'h0, sh[7:0]} : size == SZ_HALF ? {16'h0, sh[15:0]} : sh;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = size == SZ_BYTE ? 1'b0 : size == SZ_HALF ? a[0] : |a;
`else
    mis = 1'b0;
`endif
  end
endmodule

// File: rtl/dmem_bus_ctrl.sv
// dmem_bus_ctrl: data-memory access FSM with latched bus request and timeout; DMEM_MISALIGN_TRAP_EN traps misaligned accesses
module dmem_bus_ctrl
  import dmem_bus_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_write,
  input  logic [1:0]        c_size,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  output logic [31:0]       c_rdata,
  output logic              c_stall,
  output logic              c_err,
  dmem_bus_ctrl_if.master   bus
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  state_t state, nxt;
  logic [1:0] size_q, a_q, size_in, a_in;
  logic [CW-1:0] cnt;
  logic [31:0] rdata_q, lane_wdata, aligned_rdata;
  logic [3:0] be;
  logic err_q, mis, idle, tmo, done;
  // in IDLE the aligner looks at the incoming request, afterwards at the latched one
  assign idle = state == ST_IDLE;
  assign size_in = idle ? c_size : size_q;
  assign a_in = idle ? c_addr[1:0] : a_q;
  assign tmo = TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign done = state == ST_WAIT && (bus.b_ack || tmo);
  dmem_lane_align u_align (
    .size(size_in), .a(a_in), .wdata(c_wdata), .rdata(bus.b_rdata),
    .be(be), .lane_wdata(lane_wdata), .aligned_rdata(aligned_rdata), .mis(mis)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      bus.b_req <= 1'b0;
    end else begin
      state <= nxt;
      bus.b_req <= nxt == ST_WAIT;
    end
  end
  always_comb begin
    nxt = state == ST_IDLE ? (c_req ? (mis ? ST_RESP : ST_WAIT) : ST_IDLE) :
          state == ST_WAIT ? (done ? ST_RESP : ST_WAIT) : ST_IDLE;
  end
  always_comb begin
    c_stall = c_req && state != ST_RESP;
    c_err = state == ST_RESP && err_q;
    c_rdata = rdata_q;
  end
  // ack wins over a simultaneous timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.b_we <= 1'b0;
      bus.b_be <= '0;
      bus.b_addr <= '0;
      bus.b_wdata <= '0;
      size_q <= '0;
      a_q <= '0;
      cnt <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt <= state == ST_WAIT ? cnt + 1'b1 : '0;
      if (idle && c_req) begin
        bus.b_we <= c_write;
        bus.b_be <= be;
        bus.b_addr <= {c_addr[ADDR_W-1:2], 2'b00};
        bus.b_wdata <= lane_wdata;
        size_q <= c_size;
        a_q <= c_addr[1:0];
        err_q <= mis;
        if (mis) rdata_q <= '0;
      end
      if (done) begin
        rdata_q <= bus.b_ack ? aligned_rdata : '0;
        err_q <= !bus.b_ack;
      end
    end
  end
endmodule
